// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster engine. Owns the pixel-clock divider
//               and the pixel/line counters, decodes active/sync/strobe
//               flags, delays them through a LAT-deep pipeline to line up
//               with a pixel generator of known latency, and drives the
//               registered colour, HSync and VSync DAC outputs plus one-clk
//               line/frame start strobes.
//
// Ports       : clk          - system clock
//               reset        - asynchronous, active-high reset
//               enable       - low holds the engine idle (synchronous)
//               color_in     - colour from the pixel generator
//               pixel_x      - current horizontal count, 0..H_TOTAL-1
//               pixel_y      - current vertical count,   0..V_TOTAL-1
//               pix_tick     - one-clk pixel-advance strobe
//               color        - registered colour to DAC (0 when blanked)
//               HSync/VSync  - registered syncs, active level H_POL/V_POL
//               line_start   - one clk after the tick that output x==0
//               frame_start  - one clk after the tick that output (0,0)
//
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int COLOR_W  = 8,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CLK_DIV  = 1,
  parameter int LAT      = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [COLOR_W-1:0] color_in,
  output logic [10:0]        pixel_x,
  output logic [10:0]        pixel_y,
  output logic               pix_tick,
  output logic [COLOR_W-1:0] color,
  output logic               HSync,
  output logic               VSync,
  output logic               line_start,
  output logic               frame_start
);

  // --------------------------------------------------------------------------
  // Derived geometry
  // --------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] X_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] X_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] Y_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);

  // Bit positions of the decoded flag vector carried through the pipeline
  localparam int F_ACT = 4;
  localparam int F_HS  = 3;
  localparam int F_VS  = 2;
  localparam int F_LS  = 1;
  localparam int F_FS  = 0;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (H_TOTAL > 2047) begin : g_chk_htotal
      $error("vga_timing_gen: H_TOTAL exceeds 2047");
    end
    if (V_TOTAL > 2047) begin : g_chk_vtotal
      $error("vga_timing_gen: V_TOTAL exceeds 2047");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_chk_div
      $error("vga_timing_gen: CLK_DIV must be 1..16");
    end
    if (LAT < 0 || LAT > 7) begin : g_chk_lat
      $error("vga_timing_gen: LAT must be 0..7");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Pixel-clock divider
  // --------------------------------------------------------------------------
  logic [3:0] div_q, div_d;

  // Combinational so that it is constantly high when CLK_DIV == 1.
  assign pix_tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = pix_tick ? 4'd0 : div_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= 4'd0;
    end else if (!enable) begin
      div_q <= 4'd0;
    end else begin
      div_q <= div_d;
    end
  end

  // --------------------------------------------------------------------------
  // Pixel / line counters
  // --------------------------------------------------------------------------
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;

  // y advances on the same tick that x wraps, so (X_LAST,Y_LAST) goes
  // straight to (0,0) with no intermediate value visible.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_tick) begin
      if (x_q == X_LAST) begin
        x_d = 11'd0;
        y_d = (y_q == Y_LAST) ? 11'd0 : y_q + 11'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= 11'd0;
      y_q <= 11'd0;
    end else if (!enable) begin
      x_q <= 11'd0;
      y_q <= 11'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign pixel_x = x_q;
  assign pixel_y = y_q;

  // --------------------------------------------------------------------------
  // Stage-0 decode
  // --------------------------------------------------------------------------
  logic [4:0] stage0;

  always_comb begin
    stage0        = 5'd0;
    stage0[F_ACT] = (x_q < X_ACT_END) && (y_q < Y_ACT_END);
    stage0[F_HS]  = (x_q >= HS_START) && (x_q < HS_END);
    stage0[F_VS]  = (y_q >= VS_START) && (y_q < VS_END);
    stage0[F_LS]  = (x_q == 11'd0);
    stage0[F_FS]  = (x_q == 11'd0) && (y_q == 11'd0);
  end

  // --------------------------------------------------------------------------
  // Latency pipeline: advances only on pix_tick so that the decoded flags
  // stay aligned with the pixel generator regardless of CLK_DIV.
  // --------------------------------------------------------------------------
  logic [4:0] pipe_out;

  generate
    if (LAT == 0) begin : g_no_pipe
      assign pipe_out = stage0;
    end else begin : g_pipe
      logic [4:0] pipe_q [LAT];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < LAT; i++) pipe_q[i] <= 5'd0;
        end else if (!enable) begin
          for (int i = 0; i < LAT; i++) pipe_q[i] <= 5'd0;
        end else if (pix_tick) begin
          pipe_q[0] <= stage0;
          for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign pipe_out = pipe_q[LAT-1];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  logic [COLOR_W-1:0] color_q, color_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               ls_q, ls_d;
  logic               fs_q, fs_d;

  always_comb begin
    color_d = color_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_tick) begin
      color_d = pipe_out[F_ACT] ? color_in : '0;
      hsync_d = pipe_out[F_HS]  ? H_POL : ~H_POL;
      vsync_d = pipe_out[F_VS]  ? V_POL : ~V_POL;
    end
    // Strobes fall on the next clk even when the pixel period is longer.
    ls_d = pix_tick & pipe_out[F_LS];
    fs_d = pix_tick & pipe_out[F_FS];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_q <= '0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else if (!enable) begin
      color_q <= '0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      color_q <= color_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign color       = color_q;
  assign HSync       = hsync_q;
  assign VSync       = vsync_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire
